// File: rtl/breakout_pkg.sv
// Shared definitions for the breakout game: round-state encodings and the
// default game geometry used by both the controller and the graphics block.
package breakout_pkg;

    typedef enum logic [2:0] {
        NEWGAME = 3'd0,
        PLAY    = 3'd1,
        NEWBALL = 3'd2,
        OVER    = 3'd3,
        WIN     = 3'd4
    } game_state_t;

    localparam int BRICK_ROWS      = 6;
    localparam int BRICK_COLS      = 8;
    localparam int DEF_LIVES       = 3;
    localparam int DEF_BRICKS      = BRICK_ROWS * BRICK_COLS;
    localparam int DEF_TIMER_TICKS = 120;

endpackage

// File: rtl/bcd2_counter.sv
// Two-digit BCD score counter: synchronous clear, increment enable,
// wraps 99 -> 00.
module bcd2_counter (
    input  logic       clk,
    input  logic       reset,
    input  logic       clr,
    input  logic       inc,
    output logic [7:0] bcd
);

    logic [3:0] ones_reg;
    logic [3:0] tens_reg;

    always_ff @(posedge clk) begin
        if (!reset || clr) begin
            ones_reg <= 4'd0;
            tens_reg <= 4'd0;
        end else if (inc) begin
            if (ones_reg == 4'd9) begin
                ones_reg <= 4'd0;
                tens_reg <= (tens_reg == 4'd9) ? 4'd0 : tens_reg + 4'd1;
            end else begin
                ones_reg <= ones_reg + 4'd1;
            end
        end
    end

    assign bcd = {tens_reg, ones_reg};

endmodule

// File: rtl/breakout_game_ctrl.sv
// Round sequencer for breakout: state machine, lives/bricks bookkeeping,
// hit edge detection, BCD score and the refresh-tick pause timer.
module breakout_game_ctrl
    import breakout_pkg::*;
#(
    parameter int LIVES       = DEF_LIVES,
    parameter int BRICKS      = DEF_BRICKS,
    parameter int TIMER_TICKS = DEF_TIMER_TICKS
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] btn,
    input  logic       refr_tick,
    input  logic       hit,
    input  logic       miss,
    output logic       gra_still,
    output logic [2:0] game_state,
    output logic [1:0] lives,
    output logic [7:0] score,
    output logic [5:0] bricks_left,
    output logic       timer_done
);

    localparam int TW = $clog2(TIMER_TICKS + 1);
    localparam logic [1:0]    LIVES_INIT  = 2'(LIVES);
    localparam logic [5:0]    BRICKS_INIT = 6'(BRICKS);
    localparam logic [TW-1:0] TIMER_LOAD  = TW'(TIMER_TICKS);

    game_state_t   state_reg;
    logic          gra_still_reg;
    logic [1:0]    lives_reg;
    logic [5:0]    bricks_reg;
    logic [TW-1:0] timer_reg;
    logic          hit_d_reg;

    logic hit_pulse;
    logic in_play;
    logic win_now;
    logic timer_zero;
    logic timer_load;
    logic score_clr;
    logic score_inc;

    assign hit_pulse  = hit & ~hit_d_reg;
    assign in_play    = (state_reg == PLAY);
    assign win_now    = in_play && hit_pulse && (bricks_reg == 6'd1);
    assign timer_zero = (timer_reg == '0);
    // Every exit from PLAY enters a paused state, so that is when the timer loads.
    assign timer_load = win_now || (in_play && miss);
    assign score_clr  = ((state_reg == OVER) || (state_reg == WIN)) && timer_zero;
    assign score_inc  = in_play && hit_pulse;

    always_ff @(posedge clk) begin
        if (!reset) begin
            hit_d_reg <= 1'b0;
        end else begin
            hit_d_reg <= hit;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            timer_reg <= '0;
        end else if (timer_load) begin
            timer_reg <= TIMER_LOAD;
        end else if (refr_tick && !timer_zero) begin
            timer_reg <= timer_reg - TW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg     <= NEWGAME;
            gra_still_reg <= 1'b1;
            lives_reg     <= LIVES_INIT;
            bricks_reg    <= BRICKS_INIT;
        end else begin
            case (state_reg)
                NEWGAME: begin
                    if (btn != '0) begin
                        state_reg     <= PLAY;
                        gra_still_reg <= 1'b0;
                    end
                end
                PLAY: begin
                    if (hit_pulse) begin
                        bricks_reg <= bricks_reg - 6'd1;
                    end
                    if (miss) begin
                        lives_reg <= lives_reg - 2'd1;
                    end
                    // Clearing the wall wins even if the last ball was lost.
                    if (win_now) begin
                        state_reg     <= WIN;
                        gra_still_reg <= 1'b1;
                    end else if (miss) begin
                        state_reg     <= (lives_reg == 2'd1) ? OVER : NEWBALL;
                        gra_still_reg <= 1'b1;
                    end
                end
                NEWBALL: begin
                    if (timer_zero && (btn != '0)) begin
                        state_reg     <= PLAY;
                        gra_still_reg <= 1'b0;
                    end
                end
                OVER, WIN: begin
                    if (timer_zero) begin
                        state_reg  <= NEWGAME;
                        lives_reg  <= LIVES_INIT;
                        bricks_reg <= BRICKS_INIT;
                    end
                end
                default: begin
                    state_reg     <= NEWGAME;
                    gra_still_reg <= 1'b1;
                end
            endcase
        end
    end

    bcd2_counter u_score (
        .clk   (clk),
        .reset (reset),
        .clr   (score_clr),
        .inc   (score_inc),
        .bcd   (score)
    );

    assign gra_still   = gra_still_reg;
    assign game_state  = state_reg;
    assign lives       = lives_reg;
    assign bricks_left = bricks_reg;
    assign timer_done  = timer_zero;

endmodule

// File: tb/tb_breakout_game_ctrl.sv
module tb_breakout_game_ctrl;
    import breakout_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [4:0] btn = '0;
    logic       refr_tick = 1'b0;
    logic       hit = 1'b0;
    logic       miss = 1'b0;
    logic       gra_still;
    logic [2:0] game_state;
    logic [1:0] lives;
    logic [7:0] score;
    logic [5:0] bricks_left;
    logic       timer_done;

    breakout_game_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .btn         (btn),
        .refr_tick   (refr_tick),
        .hit         (hit),
        .miss        (miss),
        .gra_still   (gra_still),
        .game_state  (game_state),
        .lives       (lives),
        .score       (score),
        .bricks_left (bricks_left),
        .timer_done  (timer_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        string       name;
        logic [2:0]  st;
        logic        gs;
        logic [1:0]  lv;
        logic [7:0]  sc;
        logic [5:0]  br;
        logic        td;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    game_state_t m_state;
    logic [1:0]  m_lives;
    int          m_score;
    logic [5:0]  m_bricks;
    logic        m_td;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    function automatic logic [7:0] to_bcd(input int s);
        logic [7:0] r;
        r[7:4] = 4'((s / 10) % 10);
        r[3:0] = 4'(s % 10);
        return r;
    endfunction

    task automatic chk(input string name);
        exp_t e;
        e.cyc  = cyc;
        e.name = name;
        e.st   = m_state;
        e.gs   = (m_state != PLAY);
        e.lv   = m_lives;
        e.sc   = to_bcd(m_score);
        e.br   = m_bricks;
        e.td   = m_td;
        sb.push_back(e);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                n_checks++;
                if (e.cyc != cyc || game_state !== e.st || gra_still !== e.gs ||
                    lives !== e.lv || score !== e.sc || bricks_left !== e.br ||
                    timer_done !== e.td) begin
                    n_fail++;
                    $display("FAIL %s: got st=%0d still=%0d lives=%0d score=%h bricks=%0d tdone=%0d, expected st=%0d still=%0d lives=%0d score=%h bricks=%0d tdone=%0d (cyc %0d/%0d)",
                             e.name, game_state, gra_still, lives, score, bricks_left, timer_done,
                             e.st, e.gs, e.lv, e.sc, e.br, e.td, cyc, e.cyc);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_state  = NEWGAME;
        m_lives  = 2'd3;
        m_score  = 0;
        m_bricks = 6'd48;
        m_td     = 1'b1;
    endtask

    task automatic do_hit(input string name);
        hit = 1'b1;
        step();
        if (m_state == PLAY) begin
            m_score  = m_score + 1;
            m_bricks = m_bricks - 6'd1;
        end
        chk({name, "_rise"});
        hit = 1'b0;
        step();
        chk({name, "_fall"});
    endtask

    task automatic run_pause(input int n, input string name);
        for (int i = 1; i <= n; i++) begin
            refr_tick = 1'b1;
            step();
            refr_tick = 1'b0;
            if (i == n) m_td = 1'b1;
            chk($sformatf("%s_t%0d", name, i));
            if (i < n) begin
                step();
                chk($sformatf("%s_idle%0d", name, i));
            end
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        reset = 1'b0;
        step();
        step();
        chk("reset_state");
        reset = 1'b1;
        step();
        chk("idle_newgame");

        btn = 5'h01;
        step();
        btn = '0;
        m_state = PLAY;
        chk("start_play");
        n_checks++;
        if (game_state !== 3'd1 || gra_still !== 1'b0) begin
            n_fail++;
            $display("FAIL start_play_direct: got st=%0d still=%0d, expected st=1 still=0",
                     game_state, gra_still);
        end

        hit = 1'b1;
        step();
        m_score = 1;
        m_bricks = 6'd47;
        chk("hit_held_rise");
        for (int i = 0; i < 9; i++) begin
            step();
            chk("hit_held");
        end
        hit = 1'b0;
        step();
        chk("hit_held_low");
        do_hit("hit2");
        for (int i = 0; i < 17; i++) do_hit("hit_bcd");

        miss = 1'b1;
        step();
        miss = 1'b0;
        m_lives = 2'd2;
        m_state = NEWBALL;
        m_td = 1'b0;
        chk("miss1");
        do_hit("hit_ignored_newball");
        btn = 5'h04;
        step();
        btn = '0;
        chk("btn_early_pause");
        run_pause(120, "pause1");
        step();
        chk("pause1_no_btn");
        btn = 5'h10;
        step();
        btn = '0;
        m_state = PLAY;
        chk("resume1");

        miss = 1'b1;
        step();
        miss = 1'b0;
        m_lives = 2'd1;
        m_state = NEWBALL;
        m_td = 1'b0;
        chk("miss2");
        btn = 5'h02;
        run_pause(120, "pause2_held");
        step();
        m_state = PLAY;
        chk("held_btn_play");
        btn = '0;
        miss = 1'b1;
        step();
        miss = 1'b0;
        m_lives = 2'd0;
        m_state = OVER;
        m_td = 1'b0;
        chk("miss3_over");
        miss = 1'b1;
        step();
        miss = 1'b0;
        chk("miss_ignored_over");
        run_pause(120, "pause_over");
        step();
        model_reset();
        chk("over_to_newgame");

        btn = 5'h01;
        step();
        btn = '0;
        m_state = PLAY;
        chk("start_play2");
        for (int i = 0; i < 47; i++) do_hit("fill");
        hit = 1'b1;
        miss = 1'b1;
        step();
        hit = 1'b0;
        miss = 1'b0;
        m_score = 48;
        m_bricks = 6'd0;
        m_lives = 2'd2;
        m_state = WIN;
        m_td = 1'b0;
        chk("win_with_miss");
        run_pause(120, "pause_win");
        step();
        model_reset();
        chk("win_to_newgame");

        btn = 5'h08;
        step();
        btn = '0;
        m_state = PLAY;
        chk("start_play3");
        for (int i = 0; i < 37; i++) do_hit("to37");
        n_checks++;
        if (score !== 8'h37 || bricks_left !== 6'd11) begin
            n_fail++;
            $display("FAIL score37_direct: got score=%h bricks=%0d, expected score=37 bricks=11",
                     score, bricks_left);
        end
        reset = 1'b0;
        #2;
        reset = 1'b1;
        step();
        chk("reset_glitch_ignored");
        reset = 1'b0;
        step();
        reset = 1'b1;
        model_reset();
        chk("midgame_reset");
        n_checks++;
        if (game_state !== 3'd0 || gra_still !== 1'b1 || lives !== 2'd3 ||
            score !== 8'h00 || bricks_left !== 6'd48) begin
            n_fail++;
            $display("FAIL midgame_reset_direct: got st=%0d still=%0d lives=%0d score=%h bricks=%0d, expected st=0 still=1 lives=3 score=00 bricks=48",
                     game_state, gra_still, lives, score, bricks_left);
        end
        step();
        chk("after_reset");

        step();
        step();
        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            n_checks++;
            n_fail++;
            $display("FAIL %s: got no comparison, expected one at cyc %0d", e.name, e.cyc);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
